alu_issue_ctrl: RTL and testbench

Sequential front end that drives the combinational alu_8. It owns the Z80 accumulator (A) and flag (F) registers. It accepts one operation request at a time over a valid/ready handshake, presents A, the operand and the opcode to alu_8, and captures the ALU result and status flags. It writes back A and F, then returns the result to the requester over a second valid/ready handshake. alu_8 is instantiated beside this block by the parent; this block only drives and samples its ports.

---
 rtl/alu_ctrl_pkg.sv | 61 ++++++
 rtl/alu_issue_ctrl.sv | 131 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and helpers for the ALU issue controller: alu_8 opcode
// encodings, controller states, Z80 flag bit positions and opcode predicates.
package alu_ctrl_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_OP_W   = 5;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_XOR  = 5'd4,
    OP_SLL  = 5'd6,
    OP_SRL  = 5'd7,
    OP_SLA  = 5'd8,
    OP_SRA  = 5'd9,
    OP_RL   = 5'd10,
    OP_RR   = 5'd11,
    OP_SET  = 5'd14,
    OP_RES  = 5'd15,
    OP_TEST = 5'd16
  } opcode_t;

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // EXEC  | ALU inputs settled from latched request; capture result and write back
  // RESP  | response held on resp_* until resp_ready; may accept the next request
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Z80 F register bit positions as produced by alu_8
  localparam int FLAG_C  = 0;
  localparam int FLAG_N  = 1;
  localparam int FLAG_PV = 2;
  localparam int FLAG_H  = 4;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_S  = 7;

  // Opcodes alu_8 implements; everything else returns an error response.
  function automatic logic is_legal_op(input logic [4:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_RL, OP_RR,
      OP_SET, OP_RES, OP_TEST: legal = 1'b1;
      default:                 legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Compare mode and bit test update F only; A keeps its value.
  function automatic logic writes_acc(input logic [4:0] op, input logic cmp);
    return !cmp && (op != OP_TEST);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Sequential front end for alu_8: owns A and F, accepts one request at a
// time, drives the sibling ALU from registered state, writes back and
// returns the result over a response handshake.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_opcode,
  input  logic [DATA_W-1:0] req_operand,
  input  logic              req_load,
  input  logic              req_cmp,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] alu_flags,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic [DATA_W-1:0] resp_flags,
  output logic              resp_err,
  output logic [DATA_W-1:0] acc_q,
  output logic [DATA_W-1:0] flags_q
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [OP_W-1:0]     r_opcode;
  logic [DATA_W-1:0]   r_operand;
  logic                r_load;
  logic                r_cmp;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_flags;
  logic [DATA_W-1:0]   r_res;
  logic [DATA_W-1:0]   r_res_flags;
  logic                r_err;
  logic                w_accept;

  // Next state and handshake outputs; RESP reopens the request port when the
  // response is being taken so back-to-back operations skip IDLE.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = EXEC;
      end
      EXEC: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          req_ready   = 1'b1;
          w_state_nxt = req_valid ? EXEC : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = req_valid && req_ready;

  // State register; reset discards any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Latch the request fields on accept; they also hold the ALU b/opcode inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opcode  <= '0;
      r_operand <= '0;
      r_load    <= 1'b0;
      r_cmp     <= 1'b0;
    end else if (w_accept) begin
      r_opcode  <= req_opcode;
      r_operand <= req_operand;
      r_load    <= req_load;
      r_cmp     <= req_cmp;
    end
  end

  // Execute cycle: capture the response and write back A/F. Load and illegal
  // requests report the unchanged F so resp_flags always mirrors F after the op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_flags     <= '0;
      r_res       <= '0;
      r_res_flags <= '0;
      r_err       <= 1'b0;
    end else if (r_state == EXEC) begin
      if (r_load) begin
        r_res       <= r_operand;
        r_res_flags <= r_flags;
        r_err       <= 1'b0;
        r_acc       <= r_operand;
      end else if (!is_legal_op(r_opcode)) begin
        r_res       <= r_acc;
        r_res_flags <= r_flags;
        r_err       <= 1'b1;
      end else begin
        r_res       <= alu_out;
        r_res_flags <= alu_flags;
        r_err       <= 1'b0;
        r_flags     <= alu_flags;
        if (writes_acc(r_opcode, r_cmp)) r_acc <= alu_out;
      end
    end
  end

  assign alu_a       = r_acc;
  assign alu_b       = r_operand;
  assign alu_opcode  = r_opcode;
  assign resp_result = r_res;
  assign resp_flags  = r_res_flags;
  assign resp_err    = r_err;
  assign acc_q       = r_acc;
  assign flags_q     = r_flags;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural alu_8 stand-in drives the ALU
// inputs, a transaction-level model predicts A/F and responses, and one
// negedge process compares every cycle. Directed steps add literal pins.
module tb_alu_issue_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_opcode;
  logic [7:0] req_operand;
  logic       req_load;
  logic       req_cmp;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [4:0] alu_opcode;
  logic [7:0] alu_out;
  logic [7:0] alu_flags;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_result;
  logic [7:0] resp_flags;
  logic       resp_err;
  logic [7:0] acc_q;
  logic [7:0] flags_q;

  int checks   = 0;
  int failures = 0;

  alu_issue_ctrl #(.DATA_W(8), .OP_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_operand(req_operand),
    .req_load(req_load), .req_cmp(req_cmp),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err),
    .acc_q(acc_q), .flags_q(flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural alu_8: returns {flags, out}, flags in Z80 layout S Z - H - PV N C.
  function automatic logic [15:0] alu_fn(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  w;
    logic [15:0] ab;
    logic [7:0]  r;
    logic [2:0]  k;
    logic        h, v, n, c;
    w = '0; ab = '0; r = '0; h = 1'b0; v = 1'b0; n = 1'b0; c = 1'b0;
    k = b[2:0];
    case (op)
      5'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[7:0]; c = w[8];
        h = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      5'd1: begin
        r = a - b; c = (a < b); h = (a[3:0] < b[3:0]); n = 1'b1;
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      5'd2: begin r = a & b; h = 1'b1; v = ~^r; end
      5'd3: begin r = a | b; v = ~^r; end
      5'd4: begin r = a ^ b; v = ~^r; end
      5'd6, 5'd8: begin r = a << k; v = ~^r; end
      5'd7: begin r = a >> k; v = ~^r; end
      5'd9: begin r = $signed(a) >>> k; v = ~^r; end
      5'd10: begin ab = {a, a} << k; r = ab[15:8]; v = ~^r; end
      5'd11: begin ab = {a, a} >> k; r = ab[7:0]; v = ~^r; end
      5'd14: r = a | (8'd1 << k);
      5'd15: r = a & ~(8'd1 << k);
      5'd16: begin r = a & (8'd1 << k); h = 1'b1; end
      default: r = 8'h00;
    endcase
    return {r[7], (r == 8'h00), 1'b0, h, 1'b0, v, n, c, r};
  endfunction

  // Stand-in for the sibling alu_8 instance.
  always_comb {alu_flags, alu_out} = alu_fn(alu_opcode, alu_a, alu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model state
  logic [7:0] m_a, m_f, m_b, e_res, e_flg;
  logic [4:0] m_op;
  logic       e_err, have_resp, pend_exec, acc, cons;
  logic [4:0] q_op;
  logic [7:0] q_opnd;
  logic       q_ld, q_cm;
  logic       exp_ready;
  logic [15:0] rf;

  // Per-cycle compare: advance the model for the edge just passed, then check.
  always @(negedge clk) begin
    if (rst) begin
      m_a = 8'h00; m_f = 8'h00; m_b = 8'h00; m_op = 5'd0;
      have_resp = 1'b0; pend_exec = 1'b0; acc = 1'b0; cons = 1'b0;
      chk("rst resp_valid", resp_valid, 0);
      chk("rst acc_q", acc_q, 0);
      chk("rst flags_q", flags_q, 0);
      chk("rst resp_result", resp_result, 0);
      chk("rst resp_flags", resp_flags, 0);
      chk("rst resp_err", resp_err, 0);
    end else begin
      if (pend_exec) begin have_resp = 1'b1; pend_exec = 1'b0; end
      if (cons) have_resp = 1'b0;
      if (acc) begin
        pend_exec = 1'b1;
        m_b = q_opnd; m_op = q_op;
        if (q_ld) begin
          e_res = q_opnd; e_flg = m_f; e_err = 1'b0; m_a = q_opnd;
        end else if (!(q_op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8,
                                    5'd9, 5'd10, 5'd11, 5'd14, 5'd15, 5'd16})) begin
          e_res = m_a; e_flg = m_f; e_err = 1'b1;
        end else begin
          rf = alu_fn(q_op, m_a, q_opnd);
          e_res = rf[7:0]; e_flg = rf[15:8]; e_err = 1'b0;
          m_f = e_flg;
          if (!q_cm && q_op != 5'd16) m_a = e_res;
        end
      end
      chk("resp_valid", resp_valid, have_resp);
      if (have_resp) begin
        chk("resp_result", resp_result, e_res);
        chk("resp_flags", resp_flags, e_flg);
        chk("resp_err", resp_err, e_err);
      end
      if (!pend_exec) begin
        chk("acc_q", acc_q, m_a);
        chk("flags_q", flags_q, m_f);
        chk("alu_a", alu_a, m_a);
      end
      chk("alu_b", alu_b, m_b);
      chk("alu_opcode", alu_opcode, m_op);
      exp_ready = !pend_exec && (!have_resp || resp_ready);
      chk("req_ready", req_ready, exp_ready);
      acc    = req_valid && exp_ready;
      cons   = have_resp && resp_ready;
      q_op   = req_opcode; q_opnd = req_operand; q_ld = req_load; q_cm = req_cmp;
    end
  end

  // Offer a request (called at posedge+1) and hold it until accepted.
  task automatic send(input logic [4:0] op, input logic [7:0] opnd, input logic ld, input logic cm);
    bit ok;
    ok = 0;
    req_valid = 1'b1; req_opcode = op; req_operand = opnd; req_load = ld; req_cmp = cm;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Wait for the response and consume it (resp_ready assumed high).
  task automatic wait_resp(output logic [7:0] res, output logic [7:0] flg, output logic err);
    bit ok;
    ok = 0; res = '0; flg = '0; err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1; break; end
    end
    if (!ok) chk("resp timeout", 0, 1);
    res = resp_result; flg = resp_flags; err = resp_err;
    @(posedge clk); #1;
  endtask

  logic [7:0] r_res, r_flg;
  logic       r_err;
  bit         got;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_opcode = '0; req_operand = '0;
    req_load = 1'b0; req_cmp = 1'b0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    send(5'd0, 8'h07, 1'b1, 1'b0); wait_resp(r_res, r_flg, r_err);
    chk("load 07 result", r_res, 8'h07);
    send(5'd0, 8'h07, 1'b0, 1'b0); wait_resp(r_res, r_flg, r_err);
    chk("add 07 result", r_res, 8'h0E);
    chk("add 07 acc", acc_q, 8'h0E);

    send(5'd0, 8'hFF, 1'b1, 1'b0); wait_resp(r_res, r_flg, r_err);
    send(5'd0, 8'h01, 1'b0, 1'b0); wait_resp(r_res, r_flg, r_err);
    chk("wrap result", r_res, 8'h00);
    chk("wrap acc", acc_q, 8'h00);
    chk("wrap C", flags_q[0], 1);
    chk("wrap Z", flags_q[6], 1);
    chk("wrap flags", flags_q, 8'h51);

    send(5'd0, 8'hFE, 1'b1, 1'b0); wait_resp(r_res, r_flg, r_err);
    send(5'd1, 8'hFF, 1'b0, 1'b1); wait_resp(r_res, r_flg, r_err);
    chk("cmp result", r_res, 8'hFF);
    chk("cmp acc kept", acc_q, 8'hFE);
    chk("cmp flags", flags_q, 8'h93);

    send(5'd0, 8'h0E, 1'b1, 1'b1); wait_resp(r_res, r_flg, r_err);
    chk("load wins over cmp", acc_q, 8'h0E);
    send(5'd5, 8'h33, 1'b0, 1'b0); wait_resp(r_res, r_flg, r_err);
    chk("illegal5 err", r_err, 1);
    chk("illegal5 result", r_res, 8'h0E);
    chk("illegal5 acc", acc_q, 8'h0E);
    chk("illegal5 flags", flags_q, 8'h93);
    send(5'd31, 8'h01, 1'b0, 1'b0); wait_resp(r_res, r_flg, r_err);
    chk("illegal31 err", r_err, 1);

    send(5'd2, 8'h0A, 1'b0, 1'b0); wait_resp(r_res, r_flg, r_err);
    chk("and result", r_res, 8'h0A);
    send(5'd4, 8'hFF, 1'b0, 1'b0); wait_resp(r_res, r_flg, r_err);
    chk("xor result", r_res, 8'hF5);
    send(5'd16, 8'h01, 1'b0, 1'b0); wait_resp(r_res, r_flg, r_err);
    chk("test result", r_res, 8'h00);
    chk("test acc kept", acc_q, 8'hF5);
    send(5'd14, 8'h01, 1'b0, 1'b0); wait_resp(r_res, r_flg, r_err);
    chk("set result", r_res, 8'hF7);
    send(5'd11, 8'h04, 1'b0, 1'b0); wait_resp(r_res, r_flg, r_err);
    chk("rr result", r_res, 8'h7F);
    send(5'd9, 8'h01, 1'b0, 1'b0); wait_resp(r_res, r_flg, r_err);
    chk("sra result", r_res, 8'h3F);

    // Backpressure then back-to-back accept
    resp_ready = 1'b0;
    send(5'd0, 8'h07, 1'b1, 1'b0);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1; break; end
    end
    if (!got) chk("bp resp timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp resp_valid", resp_valid, 1);
      chk("bp resp_result", resp_result, 8'h07);
      chk("bp req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_opcode = 5'd6; req_operand = 8'h03; req_load = 1'b0; req_cmp = 1'b0;
    @(negedge clk);
    chk("b2b req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(r_res, r_flg, r_err);
    chk("sll result", r_res, 8'h38);
    chk("sll acc", acc_q, 8'h38);

    // Reset while the request is executing
    send(5'd0, 8'h01, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("async rst resp_valid", resp_valid, 0);
    chk("async rst acc", acc_q, 0);
    chk("async rst flags", flags_q, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(5'd0, 8'h22, 1'b1, 1'b0); wait_resp(r_res, r_flg, r_err);
    send(5'd0, 8'h11, 1'b0, 1'b0); wait_resp(r_res, r_flg, r_err);
    chk("post-rst add result", r_res, 8'h33);
    chk("post-rst acc", acc_q, 8'h33);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
